// File: rtl/yuv_convert_arbiter.sv
// yuv_convert_arbiter: round-robin packet sharing of one YUV444->RGB converter between two
// sources, with in-order tag FIFO return routing. Define YUV_ARB_STATS_EN for per-port packet counters.
module yuv_convert_arbiter #(
    parameter int unsigned TAG_DEPTH = 4,
    parameter int unsigned DATA_W    = 24,
    parameter int unsigned KEEP_W    = DATA_W / 8,
    parameter int unsigned DEST_W    = 1
) (
    input  logic              clk,
    input  logic              rst,
    // src0 (slave)
    input  logic              i_src0_t_valid,
    input  logic [DATA_W-1:0] i_src0_t_data,
    input  logic              i_src0_t_last,
    input  logic [KEEP_W-1:0] i_src0_t_keep,
    input  logic [KEEP_W-1:0] i_src0_t_strb,
    input  logic [DEST_W-1:0] i_src0_t_dest,
    output logic              o_src0_t_ready,
    // src1 (slave)
    input  logic              i_src1_t_valid,
    input  logic [DATA_W-1:0] i_src1_t_data,
    input  logic              i_src1_t_last,
    input  logic [KEEP_W-1:0] i_src1_t_keep,
    input  logic [KEEP_W-1:0] i_src1_t_strb,
    input  logic [DEST_W-1:0] i_src1_t_dest,
    output logic              o_src1_t_ready,
    // cv_src (master)
    output logic              o_cv_src_t_valid,
    output logic [DATA_W-1:0] o_cv_src_t_data,
    output logic              o_cv_src_t_last,
    output logic [KEEP_W-1:0] o_cv_src_t_keep,
    output logic [KEEP_W-1:0] o_cv_src_t_strb,
    output logic [DEST_W-1:0] o_cv_src_t_dest,
    input  logic              i_cv_src_t_ready,
    // cv_dst (slave)
    input  logic              i_cv_dst_t_valid,
    input  logic [DATA_W-1:0] i_cv_dst_t_data,
    input  logic              i_cv_dst_t_last,
    input  logic [KEEP_W-1:0] i_cv_dst_t_keep,
    input  logic [KEEP_W-1:0] i_cv_dst_t_strb,
    input  logic [DEST_W-1:0] i_cv_dst_t_dest,
    output logic              o_cv_dst_t_ready,
    // dst0 (master)
    output logic              o_dst0_t_valid,
    output logic [DATA_W-1:0] o_dst0_t_data,
    output logic              o_dst0_t_last,
    output logic [KEEP_W-1:0] o_dst0_t_keep,
    output logic [KEEP_W-1:0] o_dst0_t_strb,
    output logic [DEST_W-1:0] o_dst0_t_dest,
    input  logic              i_dst0_t_ready,
    // dst1 (master)
    output logic              o_dst1_t_valid,
    output logic [DATA_W-1:0] o_dst1_t_data,
    output logic              o_dst1_t_last,
    output logic [KEEP_W-1:0] o_dst1_t_keep,
    output logic [KEEP_W-1:0] o_dst1_t_strb,
    output logic [DEST_W-1:0] o_dst1_t_dest,
    input  logic              i_dst1_t_ready
`ifdef YUV_ARB_STATS_EN
    ,
    output logic [31:0]       o_stat_pkts0,
    output logic [31:0]       o_stat_pkts1
`endif
);

    localparam int unsigned PTR_W = $clog2(TAG_DEPTH);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t           r_state, w_state_nxt;
    logic             r_owner, w_owner_nxt;
    logic             r_rr, w_rr_nxt;
    logic             w_push, w_pop, w_pick;
    logic             r_tags [TAG_DEPTH];
    logic [PTR_W-1:0] r_wptr, r_rptr;
    logic [PTR_W:0]   r_count;
    logic             w_full, w_empty, w_head;
    logic             w_unused;

    assign w_full   = (r_count == (PTR_W+1)'(TAG_DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_head   = r_tags[r_rptr];
    assign w_pick   = (i_src0_t_valid && i_src1_t_valid) ? r_rr : i_src1_t_valid;
    assign w_unused = ^{i_src0_t_dest, i_src1_t_dest, i_cv_dst_t_dest};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
            r_rr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_rr    <= w_rr_nxt;
        end
    end

    // Grant only from IDLE so every packet costs one bubble cycle and a tag slot is reserved first.
    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_rr_nxt         = r_rr;
        w_push           = 1'b0;
        o_cv_src_t_valid = 1'b0;
        o_cv_src_t_data  = '0;
        o_cv_src_t_last  = 1'b0;
        o_cv_src_t_keep  = '0;
        o_cv_src_t_strb  = '0;
        o_cv_src_t_dest  = '0;
        o_src0_t_ready   = 1'b0;
        o_src1_t_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_full && (i_src0_t_valid || i_src1_t_valid)) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_BUSY;
                    w_owner_nxt = w_pick;
                end
            end
            S_BUSY: begin
                if (r_owner) begin
                    o_cv_src_t_valid = i_src1_t_valid;
                    o_cv_src_t_data  = i_src1_t_data;
                    o_cv_src_t_last  = i_src1_t_last;
                    o_cv_src_t_keep  = i_src1_t_keep;
                    o_cv_src_t_strb  = i_src1_t_strb;
                    o_src1_t_ready   = i_cv_src_t_ready;
                end else begin
                    o_cv_src_t_valid = i_src0_t_valid;
                    o_cv_src_t_data  = i_src0_t_data;
                    o_cv_src_t_last  = i_src0_t_last;
                    o_cv_src_t_keep  = i_src0_t_keep;
                    o_cv_src_t_strb  = i_src0_t_strb;
                    o_src0_t_ready   = i_cv_src_t_ready;
                end
                if (o_cv_src_t_valid && i_cv_src_t_ready && o_cv_src_t_last) begin
                    w_state_nxt = S_IDLE;
                    w_rr_nxt    = ~r_owner;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_dst0_t_valid   = 1'b0;
        o_dst1_t_valid   = 1'b0;
        o_cv_dst_t_ready = 1'b0;
        if (!w_empty) begin
            if (w_head) begin
                o_dst1_t_valid   = i_cv_dst_t_valid;
                o_cv_dst_t_ready = i_dst1_t_ready;
            end else begin
                o_dst0_t_valid   = i_cv_dst_t_valid;
                o_cv_dst_t_ready = i_dst0_t_ready;
            end
        end
    end

    assign o_dst0_t_data = i_cv_dst_t_data;
    assign o_dst0_t_last = i_cv_dst_t_last;
    assign o_dst0_t_keep = i_cv_dst_t_keep;
    assign o_dst0_t_strb = i_cv_dst_t_strb;
    assign o_dst0_t_dest = '0;
    assign o_dst1_t_data = i_cv_dst_t_data;
    assign o_dst1_t_last = i_cv_dst_t_last;
    assign o_dst1_t_keep = i_cv_dst_t_keep;
    assign o_dst1_t_strb = i_cv_dst_t_strb;
    assign o_dst1_t_dest = '0;

    assign w_pop = i_cv_dst_t_valid && o_cv_dst_t_ready && i_cv_dst_t_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < TAG_DEPTH; i++) begin
                r_tags[i] <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_tags[r_wptr] <= w_owner_nxt;
                r_wptr         <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef YUV_ARB_STATS_EN
    logic [31:0] r_stat_pkts0, r_stat_pkts1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_pkts0 <= '0;
            r_stat_pkts1 <= '0;
        end else begin
            if (o_dst0_t_valid && i_dst0_t_ready && i_cv_dst_t_last) begin
                r_stat_pkts0 <= r_stat_pkts0 + 32'd1;
            end
            if (o_dst1_t_valid && i_dst1_t_ready && i_cv_dst_t_last) begin
                r_stat_pkts1 <= r_stat_pkts1 + 32'd1;
            end
        end
    end

    assign o_stat_pkts0 = r_stat_pkts0;
    assign o_stat_pkts1 = r_stat_pkts1;
`endif

    // Converter output with no outstanding tag has nowhere to go.
    a_no_orphan_return: assert property (@(posedge clk) disable iff (!rst)
        !(i_cv_dst_t_valid && w_empty));

endmodule

// File: tb/tb_yuv_convert_arbiter.sv
// Scoreboard bench for yuv_convert_arbiter; the bench plays the converter (inverts data, keeps
// packet boundaries). Stat counters are checked when YUV_ARB_STATS_EN is defined.
module tb_yuv_convert_arbiter;

    localparam int unsigned DW = 24;
    localparam int unsigned KW = 3;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_src0_t_valid = 1'b0, i_src1_t_valid = 1'b0;
    logic [DW-1:0] i_src0_t_data = '0, i_src1_t_data = '0;
    logic          i_src0_t_last = 1'b0, i_src1_t_last = 1'b0;
    logic [KW-1:0] i_src0_t_keep = '0, i_src1_t_keep = '0;
    logic [KW-1:0] i_src0_t_strb = '0, i_src1_t_strb = '0;
    logic          o_src0_t_ready, o_src1_t_ready;
    logic          o_cv_src_t_valid, o_cv_src_t_last;
    logic [DW-1:0] o_cv_src_t_data;
    logic [KW-1:0] o_cv_src_t_keep, o_cv_src_t_strb;
    logic          o_cv_src_t_dest;
    logic          i_cv_src_t_ready = 1'b1;
    logic          i_cv_dst_t_valid = 1'b0, i_cv_dst_t_last = 1'b0;
    logic [DW-1:0] i_cv_dst_t_data = '0;
    logic [KW-1:0] i_cv_dst_t_keep = '0;
    logic          o_cv_dst_t_ready;
    logic          o_dst0_t_valid, o_dst0_t_last, o_dst0_t_dest;
    logic [DW-1:0] o_dst0_t_data;
    logic [KW-1:0] o_dst0_t_keep, o_dst0_t_strb;
    logic          i_dst0_t_ready = 1'b1;
    logic          o_dst1_t_valid, o_dst1_t_last, o_dst1_t_dest;
    logic [DW-1:0] o_dst1_t_data;
    logic [KW-1:0] o_dst1_t_keep, o_dst1_t_strb;
    logic          i_dst1_t_ready = 1'b1;
`ifdef YUV_ARB_STATS_EN
    logic [31:0]   o_stat_pkts0, o_stat_pkts1;
`endif

    yuv_convert_arbiter #(.TAG_DEPTH(4), .DATA_W(DW), .KEEP_W(KW), .DEST_W(1)) dut (
        .clk(clk), .rst(rst),
        .i_src0_t_valid(i_src0_t_valid), .i_src0_t_data(i_src0_t_data), .i_src0_t_last(i_src0_t_last),
        .i_src0_t_keep(i_src0_t_keep), .i_src0_t_strb(i_src0_t_strb), .i_src0_t_dest(1'b0),
        .o_src0_t_ready(o_src0_t_ready),
        .i_src1_t_valid(i_src1_t_valid), .i_src1_t_data(i_src1_t_data), .i_src1_t_last(i_src1_t_last),
        .i_src1_t_keep(i_src1_t_keep), .i_src1_t_strb(i_src1_t_strb), .i_src1_t_dest(1'b1),
        .o_src1_t_ready(o_src1_t_ready),
        .o_cv_src_t_valid(o_cv_src_t_valid), .o_cv_src_t_data(o_cv_src_t_data),
        .o_cv_src_t_last(o_cv_src_t_last), .o_cv_src_t_keep(o_cv_src_t_keep),
        .o_cv_src_t_strb(o_cv_src_t_strb), .o_cv_src_t_dest(o_cv_src_t_dest),
        .i_cv_src_t_ready(i_cv_src_t_ready),
        .i_cv_dst_t_valid(i_cv_dst_t_valid), .i_cv_dst_t_data(i_cv_dst_t_data),
        .i_cv_dst_t_last(i_cv_dst_t_last), .i_cv_dst_t_keep(i_cv_dst_t_keep),
        .i_cv_dst_t_strb(i_cv_dst_t_keep), .i_cv_dst_t_dest(1'b1),
        .o_cv_dst_t_ready(o_cv_dst_t_ready),
        .o_dst0_t_valid(o_dst0_t_valid), .o_dst0_t_data(o_dst0_t_data), .o_dst0_t_last(o_dst0_t_last),
        .o_dst0_t_keep(o_dst0_t_keep), .o_dst0_t_strb(o_dst0_t_strb), .o_dst0_t_dest(o_dst0_t_dest),
        .i_dst0_t_ready(i_dst0_t_ready),
        .o_dst1_t_valid(o_dst1_t_valid), .o_dst1_t_data(o_dst1_t_data), .o_dst1_t_last(o_dst1_t_last),
        .o_dst1_t_keep(o_dst1_t_keep), .o_dst1_t_strb(o_dst1_t_strb), .o_dst1_t_dest(o_dst1_t_dest),
        .i_dst1_t_ready(i_dst1_t_ready)
`ifdef YUV_ARB_STATS_EN
        ,
        .o_stat_pkts0(o_stat_pkts0),
        .o_stat_pkts1(o_stat_pkts1)
`endif
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    beat_t exp0[$], exp1[$], cvq[$];
    int    exp_order[$];
    bit    cv_hold = 1'b0;
    int    cv_src_beats = 0, cv_src_pkts = 0;
    int    d0_valid_cycles = 0, d1_valid_cycles = 0;
    int    src0_rise_cyc = -1, cv_first_cyc = -1;
    logic  prev_v0 = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, got, req);
        end
    endtask

    task automatic score(input int p, input logic [DW-1:0] d, input logic [KW-1:0] k,
                         input logic [KW-1:0] st, input logic l, input logic dst);
        beat_t e;
        checks++;
        if ((p == 0 && exp0.size() == 0) || (p == 1 && exp1.size() == 0)) begin
            errors++;
            $display("FAIL dst%0d_unexpected got data=%h last=%b required no beat", p, d, l);
            return;
        end
        e = (p == 0) ? exp0.pop_front() : exp1.pop_front();
        if (d !== e.data || k !== e.keep || st !== e.keep || l !== e.last || dst !== 1'b0) begin
            errors++;
            $display("FAIL dst%0d_beat got data=%h keep=%b strb=%b last=%b dest=%b required data=%h keep=%b last=%b dest=0",
                     p, d, k, st, l, dst, e.data, e.keep, e.last);
        end
        if (l) begin
            checks++;
            if (exp_order.size() == 0) begin
                errors++;
                $display("FAIL pkt_order got port %0d required no packet", p);
            end else begin
                int o;
                o = exp_order.pop_front();
                if (o != p) begin
                    errors++;
                    $display("FAIL pkt_order got port %0d required port %0d", p, o);
                end
            end
        end
    endtask

    // Converter model and monitor: drive cv_dst on the falling edge, sample just before the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            i_cv_dst_t_valid = !cv_hold && (cvq.size() > 0);
            i_cv_dst_t_data  = (cvq.size() > 0) ? cvq[0].data : '0;
            i_cv_dst_t_keep  = (cvq.size() > 0) ? cvq[0].keep : '0;
            i_cv_dst_t_last  = (cvq.size() > 0) ? cvq[0].last : 1'b0;
            #4;
            if (!rst) begin
                cvq.delete();
                prev_v0 = 1'b0;
            end else begin
                if (i_src0_t_valid && !prev_v0) src0_rise_cyc = cyc;
                prev_v0 = i_src0_t_valid;
                if (o_cv_src_t_valid && i_cv_src_t_ready) begin
                    if (cv_first_cyc < 0) cv_first_cyc = cyc;
                    cv_src_beats++;
                    if (o_cv_src_t_last) cv_src_pkts++;
                    cvq.push_back('{data: ~o_cv_src_t_data, keep: o_cv_src_t_keep, last: o_cv_src_t_last});
                end
                if (i_cv_dst_t_valid && o_cv_dst_t_ready) void'(cvq.pop_front());
                if (o_dst0_t_valid) d0_valid_cycles++;
                if (o_dst1_t_valid) d1_valid_cycles++;
                if (o_dst0_t_valid && i_dst0_t_ready)
                    score(0, o_dst0_t_data, o_dst0_t_keep, o_dst0_t_strb, o_dst0_t_last, o_dst0_t_dest);
                if (o_dst1_t_valid && i_dst1_t_ready)
                    score(1, o_dst1_t_data, o_dst1_t_keep, o_dst1_t_strb, o_dst1_t_last, o_dst1_t_dest);
            end
            cyc++;
        end
    end

    task automatic drive_src(input int s, input logic v, input beat_t e);
        if (s == 0) begin
            i_src0_t_valid = v; i_src0_t_data = e.data; i_src0_t_last = e.last;
            i_src0_t_keep = e.keep; i_src0_t_strb = e.keep;
        end else begin
            i_src1_t_valid = v; i_src1_t_data = e.data; i_src1_t_last = e.last;
            i_src1_t_keep = e.keep; i_src1_t_strb = e.keep;
        end
    endtask

    // Called right after driving on a falling edge; returns just before the accepting rising edge.
    task automatic wait_ready(input int s);
        int w = 0;
        forever begin
            #4;
            if ((s == 0) ? o_src0_t_ready : o_src1_t_ready) break;
            w++;
            if (w > 2000) begin
                checks++;
                errors++;
                $display("FAIL src%0d_handshake_timeout got no t_ready required t_ready within 2000 cycles", s);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic send_pkts(input int s, input int npkt, input int nbeat, input logic [DW-1:0] base);
        beat_t e;
        for (int p = 0; p < npkt; p++) begin
            for (int b = 0; b < nbeat; b++) begin
                e.data = base + DW'(p * 16 + b);
                e.keep = (b == nbeat - 1) ? 3'b011 : 3'b111;
                e.last = (b == nbeat - 1);
                if (s == 0) exp0.push_back('{data: ~e.data, keep: e.keep, last: e.last});
                else        exp1.push_back('{data: ~e.data, keep: e.keep, last: e.last});
                @(negedge clk);
                drive_src(s, 1'b1, e);
                wait_ready(s);
            end
        end
        @(negedge clk);
        drive_src(s, 1'b0, '0);
    endtask

    task automatic drain(input string name);
        int w = 0;
        while ((exp0.size() > 0 || exp1.size() > 0 || cvq.size() > 0) && w < 500) begin
            @(negedge clk);
            w++;
        end
        repeat (2) @(negedge clk);
        chk({name, "_drained"}, 32'(exp0.size() + exp1.size() + exp_order.size()), 32'd0);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout got still running required finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        beat_t e;
        int    base_pkts, base_beats;

        repeat (3) @(negedge clk);
        #3;
        chk("rst_cv_src_valid", 32'(o_cv_src_t_valid), 32'd0);
        chk("rst_src0_ready",   32'(o_src0_t_ready),   32'd0);
        chk("rst_src1_ready",   32'(o_src1_t_ready),   32'd0);
        chk("rst_dst0_valid",   32'(o_dst0_t_valid),   32'd0);
        chk("rst_dst1_valid",   32'(o_dst1_t_valid),   32'd0);
        chk("rst_cv_dst_ready", 32'(o_cv_dst_t_ready), 32'd0);

        // Both sources pending when reset releases: rr starts at src0.
        exp_order = '{0, 1, 0, 1};
        fork
            send_pkts(0, 2, 1, 24'h100000);
            send_pkts(1, 2, 1, 24'h200000);
            begin @(negedge clk); rst = 1'b1; end
        join
        drain("rr");

        // Single 3-beat packet: one IDLE bubble before the first beat.
        d1_valid_cycles = 0;
        cv_first_cyc    = -1;
        base_beats      = cv_src_beats;
        exp_order.push_back(0);
        send_pkts(0, 1, 3, 24'h0abc00);
        drain("single");
        chk("single_bubble_latency", 32'(cv_first_cyc - src0_rise_cyc), 32'd1);
        chk("single_cv_src_beats", 32'(cv_src_beats - base_beats), 32'd3);
        chk("single_dst1_never_valid", 32'(d1_valid_cycles), 32'd0);

        // Converter output stalled: only TAG_DEPTH packets may enter.
        cv_hold   = 1'b1;
        base_pkts = cv_src_pkts;
        for (int i = 0; i < 6; i++) exp_order.push_back(0);
        fork
            send_pkts(0, 6, 1, 24'h300000);
            begin
                repeat (30) @(negedge clk);
                #3;
                chk("full_accepted_pkts", 32'(cv_src_pkts - base_pkts), 32'd4);
                chk("full_cv_src_valid", 32'(o_cv_src_t_valid), 32'd0);
                chk("full_src0_ready", 32'(o_src0_t_ready), 32'd0);
                cv_hold = 1'b0;
            end
        join
        drain("full");
        chk("full_total_pkts", 32'(cv_src_pkts - base_pkts), 32'd6);

        // dst1 stalled at head blocks the dst0 packet queued behind it.
        i_dst1_t_ready  = 1'b0;
        d0_valid_cycles = 0;
        exp_order.push_back(1);
        exp_order.push_back(0);
        fork
            send_pkts(1, 1, 1, 24'h500000);
            begin repeat (3) @(negedge clk); send_pkts(0, 1, 2, 24'h600000); end
        join
        repeat (10) @(negedge clk);
        #3;
        chk("hol_dst0_blocked", 32'(d0_valid_cycles), 32'd0);
        chk("hol_dst1_presented", 32'(o_dst1_t_valid), 32'd1);
        @(negedge clk);
        i_dst1_t_ready = 1'b1;
        drain("hol");

        // Reset after beat 2 of a 4-beat packet.
        cv_hold    = 1'b1;
        base_beats = cv_src_beats;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            e = '{data: 24'h400000 + DW'(b), keep: 3'b111, last: 1'b0};
            drive_src(0, 1'b1, e);
            wait_ready(0);
        end
        @(negedge clk);
        e.data = 24'h400002;
        drive_src(0, 1'b1, e);
        rst = 1'b0;
        #3;
        chk("midrst_beats_before", 32'(cv_src_beats - base_beats), 32'd2);
        chk("midrst_cv_src_valid", 32'(o_cv_src_t_valid), 32'd0);
        chk("midrst_src0_ready",   32'(o_src0_t_ready),   32'd0);
        chk("midrst_dst0_valid",   32'(o_dst0_t_valid),   32'd0);
        chk("midrst_dst1_valid",   32'(o_dst1_t_valid),   32'd0);
        chk("midrst_cv_dst_ready", 32'(o_cv_dst_t_ready), 32'd0);
        @(negedge clk);
        drive_src(0, 1'b0, '0);
        rst             = 1'b1;
        cv_hold         = 1'b0;
        d0_valid_cycles = 0;
        exp_order.push_back(1);
        send_pkts(1, 1, 2, 24'h700000);
        drain("postrst");
        chk("postrst_dst0_idle", 32'(d0_valid_cycles), 32'd0);

        // Fresh reset, then mixed traffic: 5 packets on src0, 2 on src1.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_order = '{0, 1, 0, 1, 0, 0, 0};
        fork
            send_pkts(0, 5, 2, 24'h800000);
            send_pkts(1, 2, 1, 24'h900000);
        join
        drain("mix");
`ifdef YUV_ARB_STATS_EN
        chk("stat_pkts0", o_stat_pkts0, 32'd5);
        chk("stat_pkts1", o_stat_pkts1, 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
